// File: rtl/alu_issue_stage.sv
// alu_issue_stage: collects operand A, operand B and (optionally) an opcode
// byte from an 8-bit valid/ready stream. It drives them to an external
// combinational ALU, captures the 9-bit result for one EXEC cycle, and then
// holds that result for a downstream valid/ready handshake. It also counts
// the results accepted downstream.
// Build option: define ALU_ISSUE_OPCODE_EN to enable the opcode byte phase.
// Without it, the opcode is fixed at 3'b000 and LOAD_B goes straight to EXEC.
module alu_issue_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_byte,
  input  logic             in_byte_valid,
  output logic             out_byte_ready,
  output logic [7:0]       out_a,
  output logic [7:0]       out_b,
  output logic [2:0]       out_opcode,
  input  logic [8:0]       in_alu_result,
  output logic [8:0]       out_result,
  output logic             out_result_valid,
  input  logic             in_result_ready,
  output logic             out_carry,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic [2:0] {
    ST_LOAD_A  = 3'd0,
    ST_LOAD_B  = 3'd1,
`ifdef ALU_ISSUE_OPCODE_EN
    ST_LOAD_OP = 3'd2,
`endif
    ST_EXEC    = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [8:0]       r_result;
  logic [CNT_W-1:0] r_count;
  logic             w_byte_ready;
  logic             w_xfer;
  logic             w_res_accept;

  // Loading states are the only ones that accept bytes; HOLD drops ready,
  // so nothing can be accepted on the edge where HOLD exits.
  assign w_byte_ready = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B)
`ifdef ALU_ISSUE_OPCODE_EN
                        || (r_state == ST_LOAD_OP)
`endif
                        ;
  assign w_xfer       = in_byte_valid && w_byte_ready;
  assign w_res_accept = (r_state == ST_HOLD) && in_result_ready;

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_LOAD_A;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic for the load/exec/hold sequence
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LOAD_A: if (w_xfer) w_next = ST_LOAD_B;
`ifdef ALU_ISSUE_OPCODE_EN
      ST_LOAD_B:  if (w_xfer) w_next = ST_LOAD_OP;
      ST_LOAD_OP: if (w_xfer) w_next = ST_EXEC;
`else
      ST_LOAD_B:  if (w_xfer) w_next = ST_EXEC;
`endif
      ST_EXEC:   w_next = ST_HOLD;
      ST_HOLD:   if (in_result_ready) w_next = ST_LOAD_A;
      default:   w_next = ST_LOAD_A;
    endcase
  end

  // Operand capture on byte transfers; operands persist until overwritten
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_xfer) begin
      if (r_state == ST_LOAD_A) r_a <= in_byte;
      if (r_state == ST_LOAD_B) r_b <= in_byte;
    end
  end

`ifdef ALU_ISSUE_OPCODE_EN
  logic [2:0] r_op;

  // Opcode capture; only the low three bits of the byte are meaningful
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op <= '0;
    end else if (w_xfer && (r_state == ST_LOAD_OP)) begin
      r_op <= in_byte[2:0];
    end
  end

  assign out_opcode = r_op;
`else
  assign out_opcode = 3'b000;
`endif

  // Result capture: sample the ALU during the single EXEC cycle only
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
    end else if (r_state == ST_EXEC) begin
      r_result <= in_alu_result;
    end
  end

  // Completed-result counter; wraps silently at its width
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_res_accept) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign out_byte_ready   = w_byte_ready;
  assign out_a            = r_a;
  assign out_b            = r_b;
  assign out_result       = r_result;
  assign out_result_valid = (r_state == ST_HOLD);
  assign out_carry        = r_result[8];
  assign out_zero         = (r_result[7:0] == 8'h00);
  assign out_count        = r_count;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: drives the byte stream and models the
// external ALU. It checks captured results against a vector table and a
// queue of pending results.
module tb_alu_issue_stage;
  localparam int CNT_W = 8;
`ifdef ALU_ISSUE_OPCODE_EN
  localparam bit OPC_EN = 1'b1;
`else
  localparam bit OPC_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       in_byte;
  logic             in_byte_valid;
  logic             out_byte_ready;
  logic [7:0]       out_a;
  logic [7:0]       out_b;
  logic [2:0]       out_opcode;
  logic [8:0]       in_alu_result;
  logic [8:0]       out_result;
  logic             out_result_valid;
  logic             in_result_ready;
  logic             out_carry;
  logic             out_zero;
  logic [CNT_W-1:0] out_count;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] exp_count;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opb;
    logic [8:0] exp_op;
    logic [8:0] exp_add;
    int         hold;
    bit         rdy_early;
  } vec_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [8:0] res;
  } sb_t;

  vec_t vecs[10];
  sb_t  sbq[$];

  always #5 clk = ~clk;

  alu_issue_stage #(.CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_byte          (in_byte),
    .in_byte_valid    (in_byte_valid),
    .out_byte_ready   (out_byte_ready),
    .out_a            (out_a),
    .out_b            (out_b),
    .out_opcode       (out_opcode),
    .in_alu_result    (in_alu_result),
    .out_result       (out_result),
    .out_result_valid (out_result_valid),
    .in_result_ready  (in_result_ready),
    .out_carry        (out_carry),
    .out_zero         (out_zero),
    .out_count        (out_count)
  );

  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {a, 1'b0};
      3'd6:    return {2'b00, a[7:1]};
      default: return {1'b0, a};
    endcase
  endfunction

  // External combinational ALU
  always_comb in_alu_result = alu_f(out_a, out_b, out_opcode);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_byte_valid = 1'b0;
    repeat (gap) begin
      in_byte = 8'($urandom);
      @(negedge clk);
    end
    n = 0;
    while (!out_byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(out_byte_ready), 32'd1);
    in_byte       = b;
    in_byte_valid = 1'b1;
    @(negedge clk);
    in_byte_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                         input logic [8:0] exp, input int hold, input bit rdy_early,
                         input int gap);
    sb_t e;
    sb_t got;
    in_result_ready = rdy_early;
    send_byte(a, gap);
    send_byte(b, gap);
    if (OPC_EN) send_byte(opb, gap);
    e.a   = a;
    e.b   = b;
    e.op  = OPC_EN ? opb[2:0] : 3'd0;
    e.res = exp;
    sbq.push_back(e);
    chk("exec_valid", 32'(out_result_valid), 32'd0);
    chk("exec_ready", 32'(out_byte_ready), 32'd0);
    @(negedge clk);
    chk("hold_valid", 32'(out_result_valid), 32'd1);
    got = sbq.pop_front();
    chk("result", 32'(out_result), 32'(got.res));
    chk("carry", 32'(out_carry), 32'(got.res[8]));
    chk("zero", 32'(out_zero), 32'(got.res[7:0] == 8'h00));
    chk("opnd_a", 32'(out_a), 32'(got.a));
    chk("opnd_b", 32'(out_b), 32'(got.b));
    chk("opcode", 32'(out_opcode), 32'(got.op));
    if (!rdy_early) begin
      repeat (hold) begin
        in_byte       = 8'($urandom);
        in_byte_valid = 1'b1;
        @(negedge clk);
        chk("stall_valid", 32'(out_result_valid), 32'd1);
        chk("stall_result", 32'(out_result), 32'(got.res));
        chk("stall_ready", 32'(out_byte_ready), 32'd0);
        chk("stall_count", 32'(out_count), 32'(exp_count));
      end
      in_byte         = ~got.a;
      in_byte_valid   = 1'b1;
      in_result_ready = 1'b1;
    end
    @(negedge clk);
    exp_count       = exp_count + CNT_W'(1);
    in_byte_valid   = 1'b0;
    in_result_ready = 1'b0;
    chk("count", 32'(out_count), 32'(exp_count));
    chk("exit_valid", 32'(out_result_valid), 32'd0);
    chk("exit_ready", 32'(out_byte_ready), 32'd1);
    chk("exit_a_kept", 32'(out_a), 32'(got.a));
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] ro;

    vecs[0] = '{8'h05, 8'h03, 8'h00, 9'h008, 9'h008, 0,  1'b1};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 9'h100, 9'h100, 10, 1'b0};
    vecs[2] = '{8'h0F, 8'hF0, 8'hFA, 9'h000, 9'h0FF, 2,  1'b0};
    vecs[3] = '{8'h0F, 8'hF0, 8'h0B, 9'h0FF, 9'h0FF, 1,  1'b0};
    vecs[4] = '{8'hAA, 8'hFF, 8'h04, 9'h055, 9'h1A9, 0,  1'b0};
    vecs[5] = '{8'h80, 8'h00, 8'h05, 9'h100, 9'h080, 0,  1'b1};
    vecs[6] = '{8'h03, 8'h05, 8'h01, 9'h1FE, 9'h008, 1,  1'b0};
    vecs[7] = '{8'h81, 8'h00, 8'h06, 9'h040, 9'h081, 0,  1'b1};
    vecs[8] = '{8'h5A, 8'h00, 8'h07, 9'h05A, 9'h05A, 2,  1'b0};
    vecs[9] = '{8'h10, 8'h20, 8'h00, 9'h030, 9'h030, 0,  1'b0};

    rst_n           = 1'b0;
    in_byte         = 8'h00;
    in_byte_valid   = 1'b0;
    in_result_ready = 1'b0;
    exp_count       = '0;
    repeat (2) @(negedge clk);
    chk("rst_a", 32'(out_a), 32'd0);
    chk("rst_b", 32'(out_b), 32'd0);
    chk("rst_op", 32'(out_opcode), 32'd0);
    chk("rst_result", 32'(out_result), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_valid", 32'(out_result_valid), 32'd0);
    chk("rst_carry", 32'(out_carry), 32'd0);
    chk("rst_zero", 32'(out_zero), 32'd1);
    chk("rst_ready", 32'(out_byte_ready), 32'd1);
    rst_n = 1'b1;

    // Reset after A and B are loaded discards the partial transaction
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_a", 32'(out_a), 32'd0);
    chk("midrst_b", 32'(out_b), 32'd0);
    chk("midrst_ready", 32'(out_byte_ready), 32'd1);
    chk("midrst_valid", 32'(out_result_valid), 32'd0);
    chk("midrst_count", 32'(out_count), 32'(exp_count));

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].opb,
              OPC_EN ? vecs[i].exp_op : vecs[i].exp_add,
              vecs[i].hold, vecs[i].rdy_early, 0);
    end

    // Reset while holding a result clears it and the counter
    send_byte(8'hFF, 0);
    send_byte(8'h01, 0);
    if (OPC_EN) send_byte(8'h00, 0);
    @(negedge clk);
    chk("hrst_pre_valid", 32'(out_result_valid), 32'd1);
    chk("hrst_pre_carry", 32'(out_carry), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    exp_count = '0;
    chk("hrst_valid", 32'(out_result_valid), 32'd0);
    chk("hrst_result", 32'(out_result), 32'd0);
    chk("hrst_carry", 32'(out_carry), 32'd0);
    chk("hrst_zero", 32'(out_zero), 32'd1);
    chk("hrst_count", 32'(out_count), 32'd0);
    chk("hrst_ready", 32'(out_byte_ready), 32'd1);

    // 256 random transactions with stalls: counter wraps back to zero
    for (int k = 0; k < 256; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = 8'($urandom);
      run_txn(ra, rb, ro, alu_f(ra, rb, OPC_EN ? ro[2:0] : 3'd0),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end
    chk("wrap_count", 32'(out_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of completed-operation counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_byte  input  8  upstream operand/opcode byte.
REQ-005 SHALL have port in_byte_valid  input  1  in_byte valid this cycle.
REQ-006 SHALL have port out_byte_ready  output  1  stage accepts a byte this cycle.
REQ-007 SHALL have ports out_a, out_b  output  8 each  registered operands driven to the ALU in_a/in_b.
REQ-008 SHALL have port out_opcode  output  3  registered opcode driven to the ALU opcode.
REQ-009 SHALL have port in_alu_result  input  9  combinational ALU out_result.
REQ-010 SHALL have port out_result  output  9  captured result.
REQ-011 SHALL have port out_result_valid  output  1  out_result held for downstream.
REQ-012 SHALL have port in_result_ready  input  1  downstream accepts result.
REQ-013 SHALL have ports out_carry, out_zero  output  1 each  flags of out_result.
REQ-014 SHALL have port out_count  output  CNT_W  number of results accepted downstream.

Function
REQ-015 SHALL implement FSM states LOAD_A, LOAD_B, LOAD_OP, EXEC, HOLD.
REQ-016 Byte transfer SHALL occur only when in_byte_valid and out_byte_ready are both 1 in the same cycle.
REQ-017 out_byte_ready SHALL be 1 in LOAD_A, LOAD_B, LOAD_OP; 0 in EXEC and HOLD.
REQ-018 LOAD_A: on transfer, out_a <= in_byte, go LOAD_B; else stay.
REQ-019 LOAD_B: on transfer, out_b <= in_byte, go LOAD_OP; else stay.
REQ-020 LOAD_OP: on transfer, out_opcode <= in_byte[2:0] (in_byte[7:3] ignored), go EXEC; else stay.
REQ-021 EXEC: exactly one cycle; out_result <= in_alu_result; go HOLD.
REQ-022 Latency: out_result_valid SHALL rise 2 cycles after the opcode-byte transfer edge (EXEC cycle, then HOLD).
REQ-023 out_result_valid SHALL be 1 iff state is HOLD.
REQ-024 HOLD: stay while in_result_ready=0, out_result and flags stable; on in_result_ready=1 go LOAD_A and out_count increments by 1.
REQ-025 out_count SHALL wrap from 2^CNT_W-1 to 0 without any flag.
REQ-026 out_carry SHALL equal out_result[8]; out_zero SHALL equal (out_result[7:0]==0); both registered-derived, no combinational path from in_alu_result.
REQ-027 in_result_ready while not in HOLD SHALL be ignored.
REQ-028 No byte SHALL be accepted in the cycle HOLD exits; next acceptance earliest the following cycle.
REQ-029 out_a, out_b, out_opcode SHALL hold their values from LOAD_OP transfer until overwritten by the next transaction.

Reset
REQ-030 With rst_n=0 at a rising edge, state SHALL become LOAD_A regardless of current state, including mid-transaction.
REQ-031 Reset values: out_a=0, out_b=0, out_opcode=0, out_result=0, out_count=0; hence out_result_valid=0, out_carry=0, out_zero=1, out_byte_ready=1 after reset.
REQ-032 A partially loaded transaction SHALL be discarded by reset and not counted.

Configuration
REQ-033 Macro ALU_ISSUE_OPCODE_EN SHALL control the opcode byte phase.
REQ-034 Defined: behaviour as REQ-015..REQ-029.
REQ-035 Undefined: LOAD_OP state absent; LOAD_B transfer goes directly to EXEC; out_opcode constant 3'b000; latency rule of REQ-022 applies from the LOAD_B transfer edge.

Verification
REQ-036 Reset, then bytes 0x05, 0x03, 0x00 back-to-back, ready=1 -> out_result=0x008, carry=0, zero=0, valid 2 cycles after third byte, out_count=1.
REQ-037 Bytes 0xFF, 0x01, 0x00 -> out_result=0x100, carry=1, zero=1.
REQ-038 in_result_ready=0 for 10 cycles in HOLD -> out_result/valid stable, out_byte_ready=0, bytes presented ignored, out_count unchanged.
REQ-039 rst_n=0 after A and B loaded -> next cycle state LOAD_A, out_a=out_b=0, out_count unchanged; fresh 3-byte transaction completes correctly.
REQ-040 CNT_W=8, 256 accepted transactions -> out_count returns to 0x00; gaps in in_byte_valid stall without corruption.
REQ-041 Build without ALU_ISSUE_OPCODE_EN: bytes 0x10, 0x20 -> out_opcode=0, out_result=0x030 after 2 bytes.
